adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit adder datapath between several requesters in the ARM32 core: PC+4 incrementer, branch-target calculation, load/store address generation and spare. Each requester presents operands with a valid/ready handshake. The block grants one requester per cycle, performs the addition and holds the registered sum in a single-entry response slot, tagged with the requester index, until it is consumed.

---
 rtl/adder_arbiter.sv | 164 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter in front of one shared 32-bit adder.
// Requesters present operands on a valid/ready handshake. One requester is
// granted per cycle, its operands are added, and the registered sum is held
// in a single-entry response slot tagged with the requester index until the
// consumer takes it.
//
// Optional feature: define ADDER_ARB_FLAGS_EN to add the rsp_flags port,
// which carries {N,Z,C,V} for the registered sum.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id
`ifdef ADDER_ARB_FLAGS_EN
  ,output logic [3:0]          rsp_flags
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [31:0]    data_q, data_d;
  logic [IDW-1:0] id_q, id_d;

  logic           found;
  logic [IDW-1:0] win;
  logic           slot_free;
  logic           grant_en;
  logic           accept;
  logic [31:0]    a_sel;
  logic [31:0]    b_sel;
  logic [32:0]    sum_w;

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

  // A new response may be loaded when the slot is empty or is being drained now.
  assign slot_free = (state_q == EMPTY) | (rsp_valid & rsp_ready);

  // Round-robin search: first valid requester at or above ptr, then wrap to
  // the ones below ptr. Indices >= NREQ do not exist, so they are never granted.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_valid[j] && (IDW'(j) >= ptr_q)) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_valid[j] && (IDW'(j) < ptr_q)) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
  end

  // Grant depends only on req_valid, slot state and reset, never on operands.
  // Gating with rst_n keeps every grant low while reset is held.
  assign grant_en = found & slot_free & rst_n;

  // One-hot grant vector for the winner.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = grant_en && (win == IDW'(j));
    end
  end

  assign accept = grant_en;

  // Operand mux: pick the winning requester's 32-bit slice of each bus.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win == IDW'(j)) begin
        a_sel = req_a[32*j +: 32];
        b_sel = req_b[32*j +: 32];
      end
    end
  end

  // 33-bit sum keeps the carry out of bit 31 for the optional flags.
  assign sum_w = {1'b0, a_sel} + {1'b0, b_sel};

  // Next-state logic for the slot FSM, response registers and pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (accept) begin
      // Reload covers the simultaneous drain-and-accept case as well.
      state_d = FULL;
      data_d  = sum_w[31:0];
      id_d    = win;
      ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    end else if (rsp_valid && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Slot FSM, response registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

`ifdef ADDER_ARB_FLAGS_EN
  logic [3:0] flags_q, flags_d;

  // {N,Z,C,V} of the winning addition, loaded with the sum and held with it.
  always_comb begin
    flags_d = flags_q;
    if (accept) begin
      flags_d[3] = sum_w[31];
      flags_d[2] = (sum_w[31:0] == 32'd0);
      flags_d[1] = sum_w[32];
      flags_d[0] = (a_sel[31] == b_sel[31]) && (sum_w[31] != a_sel[31]);
    end
  end

  // Flags register, reset and loaded in step with rsp_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign rsp_flags = flags_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors and hand-written sequences for
// adder_arbiter (NREQ=4). Inputs change 1 ns after a rising edge and outputs
// are compared 2 ns after it, well away from the active edge.
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;
`ifdef ADDER_ARB_FLAGS_EN
  logic [3:0]          rsp_flags;
`endif

  int n_vec;
  int n_bad;

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef ADDER_ARB_FLAGS_EN
    ,.rsp_flags (rsp_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  initial begin
    // id, a, b, expected sum, expected {N,Z,C,V}
    vecs[0] = '{0, 32'h0000_0004, 32'h0000_1000, 32'h0000_1004, 4'b0000};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
    vecs[2] = '{2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
    vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111};
    vecs[4] = '{1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000};
    vecs[5] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1010};

    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state: no grants while reset is held even with all requesters valid.
    #12;
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'h0);
`ifdef ADDER_ARB_FLAGS_EN
    check("reset_rsp_flags", 32'(rsp_flags), 32'h0);
`endif
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Table: single requester per vector, consumer always ready.
    rsp_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      set_op(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = NREQ'(1) << vecs[v].id;
      #1;
      check($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(1) << vecs[v].id);
      next_cycle();
      req_valid = '0;
      #1;
      check($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
      check($sformatf("vec%0d_rsp_data", v), rsp_data, vecs[v].sum);
      check($sformatf("vec%0d_rsp_id", v), 32'(rsp_id), 32'(vecs[v].id));
`ifdef ADDER_ARB_FLAGS_EN
      check($sformatf("vec%0d_rsp_flags", v), 32'(rsp_flags), 32'(vecs[v].flags));
`endif
    end
    // Last vector granted requester 3, so the pointer is back at 0.

    // Round robin: all four valid for 8 cycles, grants 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i) * 32'h100, 32'(i));
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr%0d_grant", i), 32'(req_ready), 32'(1) << (i % NREQ));
      if (i > 0) begin
        check($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
        check($sformatf("rr%0d_rsp_id", i), 32'(rsp_id), 32'((i - 1) % NREQ));
        check($sformatf("rr%0d_rsp_data", i), rsp_data,
              32'((i - 1) % NREQ) * 32'h101);
      end
      next_cycle();
    end
    // Requester 3's sum (0x303) now sits in the slot.

    // Backpressure: consumer stalls 3 cycles while requester 2 waits.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'h0);
      check($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
      check($sformatf("bp%0d_rsp_data", i), rsp_data, 32'h0000_0303);
      check($sformatf("bp%0d_rsp_id", i), 32'(rsp_id), 32'h3);
      next_cycle();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = '0;
    #1;
    check("bp_next_rsp_id", 32'(rsp_id), 32'h2);
    check("bp_next_rsp_data", rsp_data, 32'h0000_0202);

    // Drain without a new accept: slot empties, data holds.
    next_cycle();
    #1;
    check("drain_rsp_valid", 32'(rsp_valid), 32'h0);
    check("drain_rsp_data_hold", rsp_data, 32'h0000_0202);
    check("drain_req_ready", 32'(req_ready), 32'h0);

    // Reset mid-operation: load 0x12345678 via requester 0 and stall.
    set_op(0, 32'h1234_0000, 32'h0000_5678);
    req_valid = 4'b0001;
    next_cycle();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check("pre_reset_rsp_data", rsp_data, 32'h1234_5678);
    req_valid = 4'b1010;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_rsp_data", rsp_data, 32'h0);
    check("midrst_rsp_id", 32'(rsp_id), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h0);
    set_op(1, 32'h0000_0010, 32'h0000_0020);
    set_op(3, 32'h0000_0300, 32'h0000_0030);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_grant", 32'(req_ready), 32'h2);
    next_cycle();
    #1;
    check("postrst_rsp_id", 32'(rsp_id), 32'h1);
    check("postrst_rsp_data", rsp_data, 32'h0000_0030);
    check("postrst_rsp_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    #1;
    check("postrst_next_grant", 32'(req_ready), 32'h8);
    req_valid = '0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
